rw_sequencer: RTL

- Bus-facing read/write stage of the 8259A PIC; sits directly upstream of the control-logic register block.
- Samples CS_n/WR_n/RD_n/A0/D[7:0] on one clock and tracks the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence.
- Emits one-cycle ICW1flag..OCW3flag strobes with a stable latched data byte, plus registered rden and A0 levels for the control logic.

---
 rtl/rw_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rw_sequencer.sv
// 8259A bus read/write stage: samples the CPU strobes, tracks the ICW1..ICW4 init
// sequence and emits one-cycle ICW/OCW strobes. Define RW_SYNC_INPUTS_EN to add input synchronizers.
module rw_sequencer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CS_n,
  input  logic          WR_n,
  input  logic          RD_n,
  input  logic          A0,
  input  logic [DW-1:0] DBusIn,
  output logic [DW-1:0] DBusOut,
  output logic          A0Out,
  output logic          rden,
  output logic          ICW1flag,
  output logic          ICW2flag,
  output logic          ICW3flag,
  output logic          ICW4flag,
  output logic          OCW1flag,
  output logic          OCW2flag,
  output logic          OCW3flag,
  output logic          initDone
);

  typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;

  logic          w_cs_n, w_wr_n, w_rd_n, w_a0;
  logic [DW-1:0] w_din;

`ifdef RW_SYNC_INPUTS_EN
  // Strobes idle high through the synchronizer; data/A0 delayed to stay aligned.
  logic [1:0]          r_cs_s, r_wr_s, r_rd_s, r_a0_s;
  logic [1:0][DW-1:0]  r_din_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_s  <= 2'b11;
      r_wr_s  <= 2'b11;
      r_rd_s  <= 2'b11;
      r_a0_s  <= 2'b00;
      r_din_s <= '0;
    end else begin
      r_cs_s  <= {r_cs_s[0], CS_n};
      r_wr_s  <= {r_wr_s[0], WR_n};
      r_rd_s  <= {r_rd_s[0], RD_n};
      r_a0_s  <= {r_a0_s[0], A0};
      r_din_s <= {r_din_s[0], DBusIn};
    end
  end
  assign w_cs_n = r_cs_s[1];
  assign w_wr_n = r_wr_s[1];
  assign w_rd_n = r_rd_s[1];
  assign w_a0   = r_a0_s[1];
  assign w_din  = r_din_s[1];
`else
  assign w_cs_n = CS_n;
  assign w_wr_n = WR_n;
  assign w_rd_n = RD_n;
  assign w_a0   = A0;
  assign w_din  = DBusIn;
`endif

  state_t        r_state, w_nstate;
  logic          r_sngl, r_ic4, w_nsngl, w_nic4;
  logic          r_wract, r_a0l;
  logic [DW-1:0] r_dat;
  logic [6:0]    r_flags, w_flags;   // {OCW3,OCW2,OCW1,ICW4,ICW3,ICW2,ICW1}
  logic          w_wr, w_commit;

  assign w_wr     = ~w_cs_n & ~w_wr_n;
  assign w_commit = r_wract & ~w_wr;

  always_comb begin
    w_nstate = r_state;
    w_nsngl  = r_sngl;
    w_nic4   = r_ic4;
    w_flags  = '0;
    if (w_commit) begin
      if (!r_a0l && r_dat[4]) begin
        w_flags[0] = 1'b1;
        w_nsngl    = r_dat[1];
        w_nic4     = r_dat[0];
        w_nstate   = WAIT_ICW2;
      end else begin
        case (r_state)
          WAIT_ICW2: if (r_a0l) begin
            w_flags[1] = 1'b1;
            w_nstate   = !r_sngl ? WAIT_ICW3 : (r_ic4 ? WAIT_ICW4 : READY);
          end
          WAIT_ICW3: if (r_a0l) begin
            w_flags[2] = 1'b1;
            w_nstate   = r_ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (r_a0l) begin
            w_flags[3] = 1'b1;
            w_nstate   = READY;
          end
          READY: begin
            // D4=1 with A0=0 was already taken as ICW1 above
            if (r_a0l)          w_flags[4] = 1'b1;
            else if (!r_dat[3]) w_flags[5] = 1'b1;
            else                w_flags[6] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= UNINIT;
      r_sngl  <= 1'b1;
      r_ic4   <= 1'b0;
      r_wract <= 1'b0;
      r_a0l   <= 1'b0;
      r_dat   <= '0;
      r_flags <= '0;
      DBusOut <= '0;
      rden    <= 1'b0;
      A0Out   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_sngl  <= w_nsngl;
      r_ic4   <= w_nic4;
      r_wract <= w_wr;
      r_flags <= w_flags;
      if (w_wr) begin
        r_dat <= w_din;
        r_a0l <= w_a0;
      end
      if (w_commit) DBusOut <= r_dat;
      rden <= ~w_cs_n & ~w_rd_n & w_wr_n;
      if (!w_cs_n) A0Out <= w_a0;
    end
  end

  assign {OCW3flag, OCW2flag, OCW1flag, ICW4flag, ICW3flag, ICW2flag, ICW1flag} = r_flags;
  assign initDone = (r_state == READY);

endmodule
